tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, which is the number of clock cycles each input vector is held; the legal range SHALL be 1..255.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start SHALL be input, 1 bit: a sweep request.
REQ-005 Port d SHALL be input, 1 bit: the output of the gate under test.
REQ-006 Ports a, b, c SHALL be outputs, 1 bit each: the drive to the gate under test; a is the MSB of the vector index, c the LSB.
REQ-007 Port busy SHALL be output, 1 bit: high while a sweep is in progress.
REQ-008 Port done SHALL be output, 1 bit: a one-cycle pulse when a sweep completes.
REQ-009 Port table SHALL be output, 8 bits: the captured truth table; bit i holds d for vector {a,b,c}=i.

Function
REQ-010 The FSM SHALL have states IDLE, HOLD and FIN, encoded as a 2-bit type.
REQ-011 In IDLE, start=1 SHALL be accepted: idx<=0, timer<=SETTLE_CYCLES-1, table<=0, next state HOLD.
REQ-012 In HOLD, {a,b,c} SHALL equal idx, registered; busy=1.
REQ-013 In HOLD, the timer SHALL decrement each cycle while nonzero.
REQ-014 In HOLD with timer=0, the block SHALL capture table[idx]<=d on that edge.
REQ-015 After the capture in REQ-014, if idx<7: idx<=idx+1 and timer reloads to SETTLE_CYCLES-1; if idx=7: next state FIN.
REQ-016 With start accepted at cycle 0, busy SHALL be high in cycles 1..8*SETTLE_CYCLES, and each vector i SHALL be driven in cycles i*S+1..(i+1)*S, where S=SETTLE_CYCLES.
REQ-017 FIN SHALL last one cycle (cycle 8S+1): done=1, busy=0, {a,b,c}=000, then return to IDLE.
REQ-018 In IDLE and FIN, {a,b,c} SHALL be 000.
REQ-019 start SHALL be ignored in HOLD; a start asserted during FIN SHALL be ignored; the earliest accepted restart is the cycle after done.
REQ-020 table SHALL hold its last completed value in IDLE until the next accepted start clears it.
REQ-021 With S=1, each vector SHALL last exactly one cycle and the sweep SHALL be 8 cycles.
REQ-022 idx SHALL be 3 bits and never wrap past 7 within a sweep.

Reset
REQ-023 rst=1 SHALL force on the next edge: state IDLE, idx 0, timer 0, table 0, {a,b,c}=000, busy 0, done 0, plus the compare outputs when enabled.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 rst mid-sweep SHALL abort the sweep with no done pulse.

Configuration
REQ-026 Macro TT_SWEEP_COMPARE_EN, when defined, SHALL add input expected[7:0] and outputs mismatch (1 bit) and err_bits (4 bits).
REQ-027 With TT_SWEEP_COMPARE_EN defined, expected SHALL be registered at start acceptance.
REQ-028 With TT_SWEEP_COMPARE_EN defined, in the FIN cycle the block SHALL update mismatch<=(table!=expected_q) and err_bits<=popcount(table^expected_q), range 0..8; both SHALL hold until the next FIN or reset.
REQ-029 With TT_SWEEP_COMPARE_EN undefined, these ports and their logic SHALL be absent.

Structure
REQ-030 Package tt_sweep_pkg SHALL hold the state typedef (IDLE/HOLD/FIN), NUM_VEC=8 and IDX_W=3.
REQ-031 The timer SHALL be one sub-module, tt_settle_timer (8-bit down-counter; load, decrement, and zero flag).

Verification
REQ-032 Scenario: S=4, d driven by a behavioural 3-input majority gate, start pulse at cycle 0 -> busy high cycles 1..32, done at cycle 33, table=8'hE8.
REQ-033 Scenario: S=1, d=a&b&c -> done at cycle 9, table=8'h80, and each vector lasts 1 cycle.
REQ-034 Scenario: start re-pulsed at cycles 5 and 20 of a running S=4 sweep -> no restart; done still at cycle 33.
REQ-035 Scenario: rst at cycle 12 of an S=4 sweep -> next cycle table=0, busy=0, {a,b,c}=000, and no done pulse.
REQ-036 Scenario: with TT_SWEEP_COMPARE_EN, gate=majority and expected=8'hE9 -> mismatch=1, err_bits=1.
REQ-037 Scenario: with TT_SWEEP_COMPARE_EN, gate=majority and expected=8'hE8 -> mismatch=0, err_bits=0.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;
  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [3:0] popcount8(input logic [NUM_VEC-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_VEC; i++) n = n + 4'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/tt_sweep_if.sv
// Sweep handshake and gate-under-test drive/observe signals.
// Compare signals exist only when TT_SWEEP_COMPARE_EN is defined.
// The captured table is called tt_table because "table" is a reserved word.
interface tt_sweep_if;
  import tt_sweep_pkg::*;
  logic               start;
  logic               d;
  logic               a, b, c;
  logic               busy;
  logic               done;
  logic [NUM_VEC-1:0] tt_table;
`ifdef TT_SWEEP_COMPARE_EN
  logic [NUM_VEC-1:0] expected;
  logic               mismatch;
  logic [3:0]         err_bits;

  modport master (output start, d, expected,
                  input  a, b, c, busy, done, tt_table, mismatch, err_bits);
  modport slave  (input  start, d, expected,
                  output a, b, c, busy, done, tt_table, mismatch, err_bits);
`else
  modport master (output start, d,
                  input  a, b, c, busy, done, tt_table);
  modport slave  (input  start, d,
                  output a, b, c, busy, done, tt_table);
`endif
endinterface

// File: rtl/tt_settle_timer.sv
// 8-bit settle down-counter: load wins over decrement, stops at zero.
module tt_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/tt_sweep.sv
// Drives all 8 input vectors to a 3-input gate, holding each SETTLE_CYCLES
// cycles, and captures the gate output into an 8-bit truth table.
// Optional expected-table compare is enabled by TT_SWEEP_COMPARE_EN.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  tt_sweep_if.slave  bus
);
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   abc;
  logic [NUM_VEC-1:0] tbl;
  logic               tmr_zero, tmr_load, tmr_dec;
  logic               accept, capture, last;

  assign last = (idx == IDX_W'(NUM_VEC - 1));

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        tmr_load  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (tmr_zero) begin
        capture = 1'b1;
        if (last) state_nxt = FIN;
        else      tmr_load  = 1'b1;
      end else begin
        tmr_dec = 1'b1;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // abc tracks the next idx so the drive is registered and already 000 in FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      abc <= '0;
      tbl <= '0;
    end else if (accept) begin
      idx <= '0;
      abc <= '0;
      tbl <= '0;
    end else if (capture) begin
      tbl[idx] <= bus.d;
      if (last) begin
        abc <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
        abc <= idx + IDX_W'(1);
      end
    end
  end

  assign {bus.a, bus.b, bus.c} = abc;
  assign bus.busy     = (state == HOLD);
  assign bus.done     = (state == FIN);
  assign bus.tt_table = tbl;

`ifdef TT_SWEEP_COMPARE_EN
  logic [NUM_VEC-1:0] exp_q;
  logic               mismatch_q;
  logic [3:0]         err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      if (accept) exp_q <= bus.expected;
      if (state == FIN) begin
        mismatch_q <= (tbl != exp_q);
        err_q      <= popcount8(tbl ^ exp_q);
      end
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_bits = err_q;
`endif
endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: two instances (S=4, S=1) driven from vector tables
// and hand sequences, checked against cycle arithmetic and the gate table.
module tb_tt_sweep;
  logic       clk = 1'b0;
  logic       rst_r, start_r, sel_r;
  logic [7:0] gate, exp_r;
  int         pass_cnt = 0;
  int         total    = 0;

  always #5 clk = ~clk;

  tt_sweep_if if4 ();
  tt_sweep_if if1 ();

  assign if4.start = start_r & ~sel_r;
  assign if1.start = start_r &  sel_r;
  assign if4.d     = gate[{if4.a, if4.b, if4.c}];
  assign if1.d     = gate[{if1.a, if1.b, if1.c}];
`ifdef TT_SWEEP_COMPARE_EN
  assign if4.expected = exp_r;
  assign if1.expected = exp_r;
`endif

  tt_sweep #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst_r), .bus(if4.slave));
  tt_sweep #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst_r), .bus(if1.slave));

  logic       busy_s, done_s;
  logic [2:0] abc_s;
  logic [7:0] tbl_s;
  assign busy_s = sel_r ? if1.busy : if4.busy;
  assign done_s = sel_r ? if1.done : if4.done;
  assign abc_s  = sel_r ? {if1.a, if1.b, if1.c} : {if4.a, if4.b, if4.c};
  assign tbl_s  = sel_r ? if1.tt_table : if4.tt_table;
`ifdef TT_SWEEP_COMPARE_EN
  logic       mis_s;
  logic [3:0] err_s;
  assign mis_s = sel_r ? if1.mismatch : if4.mismatch;
  assign err_s = sel_r ? if1.err_bits : if4.err_bits;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One sweep, start accepted on edge 0; pulses p1/p2 re-assert start,
  // rst_at asserts reset, chain asserts start right after done.
  task automatic sweep(input bit sel, input logic [7:0] g, input logic [7:0] ev,
                       input int p1, input int p2, input int rst_at, input bit chain);
    int  s, n;
    bit  ab, e_busy, e_done;
    logic [2:0] e_abc;
    s = sel ? 1 : 4;
    n = 8 * s;
    sel_r = sel; gate = g; exp_r = ev;
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      ab     = (rst_at > 0) && (cyc > rst_at);
      e_busy = !ab && (cyc <= n);
      e_done = !ab && (cyc == n + 1);
      e_abc  = e_busy ? 3'((cyc - 1) / s) : 3'd0;
      chk($sformatf("busy s%0d c%0d", s, cyc), 32'(busy_s), 32'(e_busy));
      chk($sformatf("done s%0d c%0d", s, cyc), 32'(done_s), 32'(e_done));
      chk($sformatf("abc s%0d c%0d", s, cyc), 32'(abc_s), 32'(e_abc));
      if (ab) chk($sformatf("table_abort c%0d", cyc), 32'(tbl_s), 32'h0);
      else if (cyc >= n + 1) chk($sformatf("table s%0d c%0d", s, cyc), 32'(tbl_s), 32'(g));
`ifdef TT_SWEEP_COMPARE_EN
      if (!ab && cyc == n + 2) begin
        chk("mismatch", 32'(mis_s), 32'(g != ev));
        chk("err_bits", 32'(err_s), 32'($countones(g ^ ev)));
      end
`endif
      start_r = (cyc == p1) || (cyc == p2) || (chain && cyc == n + 2);
      rst_r   = (cyc == rst_at);
      @(negedge clk);
    end
    start_r = 1'b0;
    rst_r   = 1'b0;
    if (chain) begin
      chk("restart_busy", 32'(busy_s), 32'h1);
      chk("restart_table", 32'(tbl_s), 32'h0);
      chk("restart_abc", 32'(abc_s), 32'h0);
      rst_r = 1'b1;
      @(negedge clk);
      rst_r = 1'b0;
    end
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] gate;
    logic [7:0] expv;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 8'hE8, 8'hE8};
    vecs[1] = '{1'b1, 8'h80, 8'h80};
    vecs[2] = '{1'b0, 8'hE8, 8'hE9};
    vecs[3] = '{1'b1, 8'h96, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF};
    for (int i = 6; i < 10; i++) begin
      vecs[i].sel  = 1'($urandom_range(0, 1));
      vecs[i].gate = 8'($urandom);
      vecs[i].expv = $urandom_range(0, 1) ? vecs[i].gate : 8'($urandom);
    end

    rst_r = 1'b1; start_r = 1'b0; sel_r = 1'b0; gate = 8'h00; exp_r = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst busy4", 32'(if4.busy), 32'h0);
    chk("rst done4", 32'(if4.done), 32'h0);
    chk("rst abc4", 32'({if4.a, if4.b, if4.c}), 32'h0);
    chk("rst table4", 32'(if4.tt_table), 32'h0);
    chk("rst busy1", 32'(if1.busy), 32'h0);
    chk("rst table1", 32'(if1.tt_table), 32'h0);
`ifdef TT_SWEEP_COMPARE_EN
    chk("rst mismatch", 32'(if4.mismatch), 32'h0);
    chk("rst err_bits", 32'(if4.err_bits), 32'h0);
`endif
    rst_r = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) sweep(vecs[i].sel, vecs[i].gate, vecs[i].expv, 0, 0, 0, 1'b0);

    // start during HOLD ignored
    sweep(1'b0, 8'hE8, 8'hE8, 5, 20, 0, 1'b0);
    // table held in IDLE
    repeat (5) @(negedge clk);
    chk("table_held", 32'(tbl_s), 32'hE8);
    chk("idle_busy", 32'(busy_s), 32'h0);
    // reset mid-sweep aborts
    sweep(1'b0, 8'hE8, 8'hE8, 0, 0, 12, 1'b0);
    // start in FIN ignored, start right after done accepted
    sweep(1'b0, 8'h5A, 8'h5A, 33, 0, 0, 1'b1);
    sweep(1'b1, 8'hC3, 8'h00, 9, 0, 0, 1'b1);
    // reset outranks start
    sweep(1'b1, 8'h3C, 8'h3C, 0, 0, 0, 1'b0);
    start_r = 1'b1; rst_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0; rst_r = 1'b0;
    chk("rst_prio_busy", 32'(busy_s), 32'h0);
    chk("rst_prio_table", 32'(tbl_s), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
